// File: rtl/gat_pkg.sv
// Shared types and width helpers for the GAT WH datapath.
package gat_pkg;

   localparam int unsigned DEF_WH_DATA_WIDTH   = 12;
   localparam int unsigned DEF_NUM_FEATURE_OUT = 16;
   localparam int unsigned DEF_MAX_NODES       = 168;

   typedef enum logic [0:0] {StIdle, StInSg} sg_state_e;

   function automatic int unsigned num_node_width(input int unsigned max_nodes);
      return $clog2(max_nodes);
   endfunction

   function automatic int unsigned wh_width(input int unsigned data_w,
                                            input int unsigned n_feat,
                                            input int unsigned max_nodes);
      return data_w * n_feat + num_node_width(max_nodes) + 1;
   endfunction

   // Row layout at the default array geometry; src_flag is the MSB, results the LSBs.
   typedef struct packed {
      logic                                                 src_flag;
      logic [$clog2(DEF_MAX_NODES)-1:0]                     num_node;
      logic [DEF_WH_DATA_WIDTH*DEF_NUM_FEATURE_OUT-1:0]     res;
   } wh_row_t;

endpackage

// File: rtl/wh_row_collector_if.sv
// Valid/ready stream carrying WH rows and their subgraph-last tag to the DMVM stage.
interface wh_row_collector_if #(
   parameter int unsigned WIDTH = 8
);
   logic             vld;
   logic             rdy;
   logic [WIDTH-1:0] data;
   logic             sg_last;

   modport master (output vld, output data, output sg_last, input rdy);
   modport slave  (input vld, input data, input sg_last, output rdy);
endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; the head is on rdata whenever empty is low.
module sync_fifo_fwft #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop frees the slot the push lands in, so push-while-full is fine with a pop.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/wh_row_collector.sv
// Captures one WH row per PE-array completion, writes it to the WH BRAM and queues it
// with a subgraph-last tag for the DMVM stage.
module wh_row_collector
   import gat_pkg::*;
#(
   parameter int unsigned WH_DATA_WIDTH   = 12,
   parameter int unsigned NUM_FEATURE_OUT = 16,
   parameter int unsigned MAX_NODES       = 168,
   parameter int unsigned TOTAL_NODES     = 13264,
   parameter int unsigned FIFO_DEPTH      = 8,
   parameter int unsigned AFULL_MARGIN    = 3
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic                                                  pe_res_vld_i,
   input  logic [WH_DATA_WIDTH*NUM_FEATURE_OUT-1:0]              pe_res_i,
   input  logic [num_node_width(MAX_NODES)-1:0]                  num_node_i,
   input  logic                                                  src_flag_i,
   output logic                                                  stall_o,
   output logic                                                  wh_wea_o,
   output logic [$clog2(TOTAL_NODES)-1:0]                        wh_addra_o,
   output logic [wh_width(WH_DATA_WIDTH, NUM_FEATURE_OUT, MAX_NODES)-1:0] wh_dina_o,
   wh_row_collector_if.master                                    wh,
   output logic [$clog2(TOTAL_NODES)-1:0]                        row_cnt_o,
   output logic                                                  overflow_o,
   output logic                                                  seq_err_o
);
   localparam int unsigned NUM_NODE_WIDTH  = num_node_width(MAX_NODES);
   localparam int unsigned WH_RESULT_WIDTH = WH_DATA_WIDTH * NUM_FEATURE_OUT;
   localparam int unsigned WH_WIDTH        = wh_width(WH_DATA_WIDTH, NUM_FEATURE_OUT, MAX_NODES);
   localparam int unsigned WH_ADDR_W       = $clog2(TOTAL_NODES);
   localparam int unsigned CNT_W           = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic                       src_flag;
      logic [NUM_NODE_WIDTH-1:0]  num_node;
      logic [WH_RESULT_WIDTH-1:0] res;
   } row_t;

   row_t                row;
   sg_state_e           state_q, state_d;
   logic [NUM_NODE_WIDTH-1:0] remaining_q, remaining_d;
   logic                single_row;
   logic                sg_last;
   logic                seq_err_set;
   logic                pop;
   logic                accept;
   logic [WH_WIDTH:0]   fifo_rdata;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   logic [CNT_W-1:0]    count_next;
   logic [WH_ADDR_W-1:0] addr_q, addra_q, row_cnt_q;
   logic [WH_WIDTH-1:0] dina_q;
   logic                wea_q, stall_q, overflow_q, seq_err_q;

   assign row = '{src_flag: src_flag_i, num_node: num_node_i, res: pe_res_i};
   // num_node of 0 is malformed and handled as a one-node subgraph.
   assign single_row = (num_node_i <= NUM_NODE_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      if (pe_res_vld_i) begin
         if (src_flag_i) begin
            state_d     = single_row ? StIdle : StInSg;
            remaining_d = single_row ? '0 : num_node_i - NUM_NODE_WIDTH'(1);
         end else if (state_q == StInSg) begin
            remaining_d = remaining_q - NUM_NODE_WIDTH'(1);
            if (remaining_q == NUM_NODE_WIDTH'(1)) state_d = StIdle;
         end
      end
   end

   always_comb begin
      sg_last     = 1'b0;
      seq_err_set = 1'b0;
      unique case (state_q)
         StIdle: begin
            sg_last     = !src_flag_i || single_row;
            seq_err_set = !src_flag_i || (num_node_i == '0);
         end
         StInSg: begin
            sg_last     = src_flag_i ? single_row : (remaining_q == NUM_NODE_WIDTH'(1));
            seq_err_set = src_flag_i;
         end
         default: ;
      endcase
   end

   assign pop    = wh.vld && wh.rdy;
   assign accept = pe_res_vld_i && (!fifo_full || pop);

   sync_fifo_fwft #(
      .WIDTH (WH_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .wdata ({sg_last, row}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign wh.vld     = !fifo_empty;
   assign wh.data    = fifo_rdata[WH_WIDTH-1:0];
   assign wh.sg_last = fifo_rdata[WH_WIDTH];
   assign count_next = fifo_count + CNT_W'(accept) - CNT_W'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q     <= '0;
         addra_q    <= '0;
         dina_q     <= '0;
         wea_q      <= 1'b0;
         row_cnt_q  <= '0;
         stall_q    <= 1'b0;
         overflow_q <= 1'b0;
         seq_err_q  <= 1'b0;
      end else begin
         wea_q   <= pe_res_vld_i;
         // Looks at next-cycle occupancy so stall rises together with the count.
         stall_q <= (CNT_W'(FIFO_DEPTH) - count_next) <= CNT_W'(AFULL_MARGIN);
         if (pe_res_vld_i) begin
            dina_q    <= row;
            addra_q   <= addr_q;
            addr_q    <= (addr_q == WH_ADDR_W'(TOTAL_NODES - 1)) ? '0 : addr_q + WH_ADDR_W'(1);
            row_cnt_q <= row_cnt_q + WH_ADDR_W'(1);
            if (!accept)     overflow_q <= 1'b1;
            if (seq_err_set) seq_err_q  <= 1'b1;
         end
      end
   end

   assign wh_wea_o   = wea_q;
   assign wh_addra_o = addra_q;
   assign wh_dina_o  = dina_q;
   assign stall_o    = stall_q;
   assign row_cnt_o  = row_cnt_q;
   assign overflow_o = overflow_q;
   assign seq_err_o  = seq_err_q;

endmodule

// File: tb/tb_wh_row_collector.sv
// Directed, table-driven bench for wh_row_collector at a small array geometry.
module tb_wh_row_collector;
   import gat_pkg::*;

   localparam int unsigned WDW  = 12;
   localparam int unsigned NFO  = 4;
   localparam int unsigned MAXN = 168;
   localparam int unsigned TOT  = 5;
   localparam int unsigned FD   = 4;
   localparam int unsigned AFM  = 1;
   localparam int unsigned NNW  = num_node_width(MAXN);
   localparam int unsigned RW   = WDW * NFO;
   localparam int unsigned WW   = wh_width(WDW, NFO, MAXN);
   localparam int unsigned AW   = $clog2(TOT);
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   typedef struct {
      logic          rst;
      logic          vld;
      logic          src;
      logic [NNW-1:0] nn;
      logic [RW-1:0] res;
      logic          rdy;
      logic          e_wea;
      logic [AW-1:0] e_addr;
      logic          e_vld;
      logic          e_last;
      logic [WW-1:0] e_data;
      logic          e_stall;
      logic          e_ovf;
      logic          e_serr;
      logic [AW-1:0] e_cnt;
   } vec_t;

   logic           clk;
   logic           rst;
   logic           pe_res_vld;
   logic [RW-1:0]  pe_res;
   logic [NNW-1:0] num_node;
   logic           src_flag;
   logic           stall;
   logic           wea;
   logic [AW-1:0]  addra;
   logic [WW-1:0]  dina;
   logic [AW-1:0]  row_cnt;
   logic           overflow;
   logic           seq_err;
   int             total;
   int             bad;

   wh_row_collector_if #(.WIDTH(WW)) wh_if ();

   wh_row_collector #(
      .WH_DATA_WIDTH   (WDW),
      .NUM_FEATURE_OUT (NFO),
      .MAX_NODES       (MAXN),
      .TOTAL_NODES     (TOT),
      .FIFO_DEPTH      (FD),
      .AFULL_MARGIN    (AFM)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pe_res_vld_i (pe_res_vld),
      .pe_res_i     (pe_res),
      .num_node_i   (num_node),
      .src_flag_i   (src_flag),
      .stall_o      (stall),
      .wh_wea_o     (wea),
      .wh_addra_o   (addra),
      .wh_dina_o    (dina),
      .wh           (wh_if),
      .row_cnt_o    (row_cnt),
      .overflow_o   (overflow),
      .seq_err_o    (seq_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [WW-1:0] pk(input logic s, input logic [NNW-1:0] n,
                                        input logic [RW-1:0] r);
      return {s, n, r};
   endfunction

   function automatic vec_t mk(input logic r, v, s, input logic [NNW-1:0] n,
                               input logic [RW-1:0] res, input logic rd,
                               input logic ewea, input logic [AW-1:0] eaddr,
                               input logic evld, elast, input logic [WW-1:0] edata,
                               input logic estall, eovf, eserr, input logic [AW-1:0] ecnt);
      vec_t t;
      t.rst = r; t.vld = v; t.src = s; t.nn = n; t.res = res; t.rdy = rd;
      t.e_wea = ewea; t.e_addr = eaddr; t.e_vld = evld; t.e_last = elast; t.e_data = edata;
      t.e_stall = estall; t.e_ovf = eovf; t.e_serr = eserr; t.e_cnt = ecnt;
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, v, s, input logic [NNW-1:0] n, input logic [RW-1:0] res,
                        input logic rd);
      rst = r; pe_res_vld = v; src_flag = s; num_node = n; pe_res = res; wh_if.rdy = rd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t          vecs[$];
      vec_t          v;
      logic [RW-1:0] r1, ra, rb, rc, g0, h0, h1;
      logic [RW-1:0] d[6];
      logic [RW-1:0] e[6];
      logic [RW-1:0] f[3];
      int            n;

      total = 0;
      bad = 0;
      rst = 1'b1; pe_res_vld = 1'b0; src_flag = 1'b0; num_node = '0; pe_res = '0;
      wh_if.rdy = 1'b0;

      r1 = {12'h7FF, 12'h003, 12'h002, 12'hFFF};
      ra = 48'h111_222_333_444;
      rb = 48'h800_7FF_001_FFE;
      rc = 48'h0A5_5A0_F0F_0F0;
      g0 = 48'hC0C_0C0_ABC_DEF;
      h0 = 48'h1A1_2B2_3C3_4D4;
      h1 = 48'hFED_CBA_987_654;
      for (int i = 0; i < 6; i++) begin
         d[i] = {12'hD00 + 12'(i), 36'h5A5_A5A_00F};
         e[i] = {12'hE00 + 12'(i), 36'h0F0_123_321};
      end
      for (int i = 0; i < 3; i++) f[i] = {12'hF00 + 12'(i), 36'hAAA_555_777};

      // rst vld src nn res rdy | wea addr vld last data | stall ovf serr cnt
      vecs.push_back(mk(H,L,L,8'd0,'0,L,    L,3'd0,L,L,'0,                         L,L,L,3'd0));
      vecs.push_back(mk(L,H,H,8'd1,r1,L,    H,3'd0,H,H,57'h101_7FF_003_002_FFF,    L,L,L,3'd1));
      vecs.push_back(mk(L,L,L,8'd0,'0,H,    L,3'd0,L,L,'0,                         L,L,L,3'd1));
      vecs.push_back(mk(L,H,H,8'd3,ra,H,    H,3'd1,H,L,pk(H,8'd3,ra),              L,L,L,3'd2));
      vecs.push_back(mk(L,H,L,8'd3,rb,H,    H,3'd2,H,L,pk(L,8'd3,rb),              L,L,L,3'd3));
      vecs.push_back(mk(L,H,L,8'd3,rc,H,    H,3'd3,H,H,pk(L,8'd3,rc),              L,L,L,3'd4));
      vecs.push_back(mk(L,L,L,8'd0,'0,H,    L,3'd0,L,L,'0,                         L,L,L,3'd4));
      // Fill with rdy low: stall at 3 entries, drop on the 5th, push+pop while full on the 6th.
      vecs.push_back(mk(L,H,H,8'd1,d[0],L,  H,3'd4,H,H,pk(H,8'd1,d[0]),            L,L,L,3'd5));
      vecs.push_back(mk(L,H,H,8'd1,d[1],L,  H,3'd0,H,H,pk(H,8'd1,d[0]),            L,L,L,3'd6));
      vecs.push_back(mk(L,H,H,8'd1,d[2],L,  H,3'd1,H,H,pk(H,8'd1,d[0]),            H,L,L,3'd7));
      vecs.push_back(mk(L,H,H,8'd1,d[3],L,  H,3'd2,H,H,pk(H,8'd1,d[0]),            H,L,L,3'd0));
      vecs.push_back(mk(L,H,H,8'd1,d[4],L,  H,3'd3,H,H,pk(H,8'd1,d[0]),            H,H,L,3'd1));
      vecs.push_back(mk(L,H,H,8'd1,d[5],H,  H,3'd4,H,H,pk(H,8'd1,d[1]),            H,H,L,3'd2));
      vecs.push_back(mk(L,L,L,8'd0,'0,H,    L,3'd0,H,H,pk(H,8'd1,d[2]),            H,H,L,3'd2));
      vecs.push_back(mk(L,L,L,8'd0,'0,H,    L,3'd0,H,H,pk(H,8'd1,d[3]),            L,H,L,3'd2));
      vecs.push_back(mk(L,L,L,8'd0,'0,H,    L,3'd0,H,H,pk(H,8'd1,d[5]),            L,H,L,3'd2));
      vecs.push_back(mk(L,L,L,8'd0,'0,H,    L,3'd0,L,L,'0,                         L,H,L,3'd2));
      // Subgraph of 4 interrupted by a new source with 2 remaining, then idle-state errors.
      vecs.push_back(mk(L,H,H,8'd4,e[0],H,  H,3'd0,H,L,pk(H,8'd4,e[0]),            L,H,L,3'd3));
      vecs.push_back(mk(L,H,L,8'd4,e[1],H,  H,3'd1,H,L,pk(L,8'd4,e[1]),            L,H,L,3'd4));
      vecs.push_back(mk(L,H,H,8'd2,e[2],H,  H,3'd2,H,L,pk(H,8'd2,e[2]),            L,H,H,3'd5));
      vecs.push_back(mk(L,H,L,8'd2,e[3],H,  H,3'd3,H,H,pk(L,8'd2,e[3]),            L,H,H,3'd6));
      vecs.push_back(mk(L,H,L,8'd2,e[4],H,  H,3'd4,H,H,pk(L,8'd2,e[4]),            L,H,H,3'd7));
      vecs.push_back(mk(L,H,H,8'd0,e[5],H,  H,3'd0,H,H,pk(H,8'd0,e[5]),            L,H,H,3'd0));
      vecs.push_back(mk(L,L,L,8'd0,'0,L,    L,3'd0,H,H,pk(H,8'd0,e[5]),            L,H,H,3'd0));
      vecs.push_back(mk(L,L,L,8'd0,'0,H,    L,3'd0,L,L,'0,                         L,H,H,3'd0));
      // Buffer three rows, then reset with a row arriving in the reset cycle.
      vecs.push_back(mk(L,H,H,8'd1,f[0],L,  H,3'd1,H,H,pk(H,8'd1,f[0]),            L,H,H,3'd1));
      vecs.push_back(mk(L,H,H,8'd1,f[1],L,  H,3'd2,H,H,pk(H,8'd1,f[0]),            L,H,H,3'd2));
      vecs.push_back(mk(L,H,H,8'd1,f[2],L,  H,3'd3,H,H,pk(H,8'd1,f[0]),            H,H,H,3'd3));
      vecs.push_back(mk(H,H,H,8'd1,g0,L,    L,3'd0,L,L,'0,                         L,L,L,3'd0));
      vecs.push_back(mk(L,H,H,8'd1,g0,L,    H,3'd0,H,H,pk(H,8'd1,g0),              L,L,L,3'd1));

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         drive(v.rst, v.vld, v.src, v.nn, v.res, v.rdy);
         check($sformatf("v%0d wea", i),      64'(wea),      64'(v.e_wea));
         check($sformatf("v%0d vld", i),      64'(wh_if.vld), 64'(v.e_vld));
         check($sformatf("v%0d stall", i),    64'(stall),    64'(v.e_stall));
         check($sformatf("v%0d overflow", i), 64'(overflow), 64'(v.e_ovf));
         check($sformatf("v%0d seq_err", i),  64'(seq_err),  64'(v.e_serr));
         check($sformatf("v%0d row_cnt", i),  64'(row_cnt),  64'(v.e_cnt));
         if (v.e_wea) begin
            check($sformatf("v%0d addra", i), 64'(addra), 64'(v.e_addr));
            check($sformatf("v%0d dina", i),  64'(dina),  64'(pk(v.src, v.nn, v.res)));
         end
         if (v.e_vld) begin
            check($sformatf("v%0d data", i),    64'(wh_if.data),    64'(v.e_data));
            check($sformatf("v%0d sg_last", i), 64'(wh_if.sg_last), 64'(v.e_last));
         end
      end

      // Head holds while the consumer stalls, then a two-node subgraph drains in order.
      drive(L, H, H, 8'd2, h0, L);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("hold%0d vld", k),     64'(wh_if.vld),     64'(1));
         check($sformatf("hold%0d data", k),    64'(wh_if.data),    64'(pk(H, 8'd1, g0)));
         check($sformatf("hold%0d sg_last", k), 64'(wh_if.sg_last), 64'(1));
         if (k < 2) drive(L, L, L, 8'd0, '0, L);
      end
      drive(L, H, L, 8'd2, h1, H);
      check("h_src data",    64'(wh_if.data),    64'(pk(H, 8'd2, h0)));
      check("h_src sg_last", 64'(wh_if.sg_last), 64'(0));
      drive(L, L, L, 8'd0, '0, H);
      check("h_end data",    64'(wh_if.data),    64'(pk(L, 8'd2, h1)));
      check("h_end sg_last", 64'(wh_if.sg_last), 64'(1));
      n = 0;
      while (wh_if.vld && n < 8) begin
         drive(L, L, L, 8'd0, '0, H);
         n++;
      end
      check("drain_cycles", 64'(n),        64'(1));
      check("h row_cnt",    64'(row_cnt),  64'(3));
      check("h seq_err",    64'(seq_err),  64'(0));
      check("h overflow",   64'(overflow), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
